cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 84 ++++++++
 tb/tb_cache_fill_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues BLOCK_WORDS pipelined word reads to main memory
// and streams the returned words into the data array, writing the tag with the final word.
module cache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [15:0]                    miss_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data,
  output logic                           fsm_busy,
  output logic                           mem_req,
  output logic [15:0]                    memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] data_array_word,
  output logic [15:0]                    fill_data,
  output logic                           write_tag_array
);

  localparam int unsigned IdxW = $clog2(BLOCK_WORDS);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] BlockCnt = CntW'(BLOCK_WORDS);
  localparam logic [CntW-1:0] LastIdx  = CntW'(BLOCK_WORDS - 1);
  // Clears the word-offset bits plus the byte-within-word bit.
  localparam logic [15:0] BaseMask = ~((16'd1 << CntW) - 16'd1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] req_cnt_q;
  logic [CntW-1:0] rcv_cnt_q;
  logic [15:0]     base_q;

  logic miss_accept;
  logic req_fire;
  logic rcv_fire;
  logic rcv_last;

  always_comb begin
    miss_accept = (state_q == StIdle) && miss_detected;
    req_fire    = (state_q == StWait) && (req_cnt_q < BlockCnt);
    rcv_fire    = (state_q == StWait) && memory_data_valid && (rcv_cnt_q < BlockCnt);
    rcv_last    = rcv_fire && (rcv_cnt_q == LastIdx);
  end

  // Outputs are combinational so returned words pass straight through to the data array.
  always_comb begin
    fsm_busy         = miss_accept || (state_q == StWait);
    mem_req          = req_fire;
    memory_address   = req_fire ? (base_q + (16'(req_cnt_q) << 1)) : 16'h0000;
    write_data_array = rcv_fire;
    data_array_word  = rcv_fire ? rcv_cnt_q[IdxW-1:0] : '0;
    fill_data        = rcv_fire ? memory_data : 16'h0000;
    write_tag_array  = rcv_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      base_q    <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_detected) begin
            base_q    <= miss_address & BaseMask;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (req_fire) req_cnt_q <= req_cnt_q + 1'b1;
          if (rcv_fire) rcv_cnt_q <= rcv_cnt_q + 1'b1;
          if (rcv_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm (BLOCK_WORDS=8) with hand-derived cycle-by-cycle expectations.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int total = 0;
  int bad   = 0;

  cache_fill_fsm #(.BLOCK_WORDS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data      (memory_data),
    .fsm_busy         (fsm_busy),
    .mem_req          (mem_req),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .data_array_word  (data_array_word),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic busy_exp);
    check({tag, " busy"}, 16'(fsm_busy), 16'(busy_exp));
    check({tag, " req"}, 16'(mem_req), 16'h0);
    check({tag, " addr"}, memory_address, 16'h0000);
    check({tag, " wr"}, 16'(write_data_array), 16'h0);
    check({tag, " word"}, 16'(data_array_word), 16'h0);
    check({tag, " data"}, fill_data, 16'h0000);
    check({tag, " tag"}, 16'(write_tag_array), 16'h0);
  endtask

  task automatic idle_inputs();
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
  endtask

  // Runs one complete fill: miss in cycle 0, each word returned lat cycles after its request.
  task automatic run_fill(input logic [15:0] addr, input logic [15:0] base, input int lat,
                          input logic second_miss);
    logic        v;
    int          w;
    logic [15:0] exp_addr;
    miss_detected = 1'b1;
    miss_address  = addr;
    memory_data_valid = 1'b0;
    #1;
    check($sformatf("%h c0 busy", addr), 16'(fsm_busy), 16'h1);
    check($sformatf("%h c0 req", addr), 16'(mem_req), 16'h0);
    check($sformatf("%h c0 wr", addr), 16'(write_data_array), 16'h0);
    tick();
    for (int c = 1; c <= 9 + lat; c++) begin
      miss_detected     = second_miss && (c <= 8 + lat);
      miss_address      = 16'h4000;
      v                 = (c >= 1 + lat) && (c <= 8 + lat);
      w                 = c - 1 - lat;
      memory_data_valid = v;
      memory_data       = v ? 16'hD000 + 16'(w) : 16'h5555;
      exp_addr          = (c <= 8) ? base + 16'(2 * (c - 1)) : 16'h0000;
      #1;
      check($sformatf("%h c%0d req", addr, c), 16'(mem_req), 16'(c <= 8));
      check($sformatf("%h c%0d addr", addr, c), memory_address, exp_addr);
      check($sformatf("%h c%0d wr", addr, c), 16'(write_data_array), 16'(v));
      check($sformatf("%h c%0d word", addr, c), 16'(data_array_word), v ? 16'(w) : 16'h0);
      check($sformatf("%h c%0d data", addr, c), fill_data, v ? 16'hD000 + 16'(w) : 16'h0000);
      check($sformatf("%h c%0d tag", addr, c), 16'(write_tag_array), 16'(c == 8 + lat));
      check($sformatf("%h c%0d busy", addr, c), 16'(fsm_busy), 16'(c <= 8 + lat));
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_quiet("reset", 1'b0);

    // A miss in IDLE raises busy combinationally, before any state change.
    miss_detected = 1'b1;
    #1;
    check("reset miss busy", 16'(fsm_busy), 16'h1);
    miss_detected = 1'b0;
    #1;

    // Returned data while idle must be dropped.
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    #1;
    check_quiet("idle valid", 1'b0);
    tick();
    check_quiet("idle valid next", 1'b0);
    idle_inputs();
    tick();

    run_fill(16'h1236, 16'h1230, 4, 1'b0);
    run_fill(16'hFFFE, 16'hFFF0, 1, 1'b0);
    run_fill(16'h1236, 16'h1230, 2, 1'b1);

    // Abort: reset asserted during cycle 6 of a latency-4 fill.
    miss_detected = 1'b1;
    miss_address  = 16'h2468;
    tick();
    miss_detected = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      memory_data_valid = (c >= 5);
      memory_data       = 16'hA000 + 16'(c);
      rst               = (c == 6);
      #1;
      check($sformatf("abort c%0d req", c), 16'(mem_req), 16'h1);
      check($sformatf("abort c%0d addr", c), memory_address, 16'h2460 + 16'(2 * (c - 1)));
      tick();
    end
    rst = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hC000 + 16'(c);
      #1;
      check_quiet($sformatf("abort c%0d", c), 1'b0);
      tick();
    end
    idle_inputs();
    tick();

    run_fill(16'h0047, 16'h0040, 3, 1'b0);
    tick();
    check_quiet("final", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
